ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
Built-in self-test initiator for the team's 64x8 single-port RAM. It drives the RAM's write-enable, data-in and address pins and checks its data-out against a March C- sequence. It sits between the RAM instance and system control, and reports a pass/fail result. On the first mismatch it captures the address, the expected data and the read data.

Parameters:
AW, 6, RAM address width (depth = 2**AW).
DW, 8, RAM data width.
RD_LAT, 1, RAM read latency in clocks. Legal values are 0 (async read), 1 and 2.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, synchronous, active-high.
start  input  1  one-cycle request to run the test. Sampled only in IDLE.
busy  output  1  high while a test runs.
done  output  1  one-cycle pulse when a test ends, whether it passed or failed.
pass  output  1  result. Valid from done until the next accepted start.
fail_addr  output  AW  address of the first mismatch.
fail_exp  output  DW  expected data at the first mismatch.
fail_got  output  DW  data read at the first mismatch.
ram_wren  output  1  RAM write enable, registered.
ram_din  output  DW  RAM write data, registered.
ram_addr  output  AW  RAM address, registered.
ram_dout  input  DW  RAM read data.

Behaviour:
- Reset takes effect on the next clk edge, including mid-test. After reset:
  - busy, done, pass, fail_* = 0.
  - ram_wren, ram_din, ram_addr = 0.
  - FSM = IDLE.
- Background patterns: B0 = all zeros, B1 = ~B0.
- FSM states: IDLE, RUN(element, addr, phase), DONE.
- start in IDLE:
  - Next cycle: busy=1, pass=0, fail_* = 0, first operation driven.
  - start while busy is ignored.
- March elements, run in order:
  - M0: up, W B0.
  - M1: up, R B0 then W B1.
  - M2: up, R B1 then W B0.
  - M3: down, R B0 then W B1.
  - M4: down, R B1 then W B0.
  - M5: up, R B0.
- Address order: "up" runs 0..2**AW-1; "down" runs 2**AW-1..0. The address counter wraps inside an element with no extra cycle, and the next element starts on the following cycle.
- Read phase:
  - ram_addr is held and ram_wren=0 for RD_LAT+1 cycles.
  - ram_dout is compared with the expected value on the last cycle of the read phase.
- Write phase: one cycle with ram_wren=1 and ram_din = pattern. ram_addr is the same address as the preceding read.
- Cycle count with no failure (2**AW=64): busy stays high for exactly 64 + 4*64*(RD_LAT+2) + 64*(RD_LAT+1) cycles, i.e. 640 / 960 / 1280 for RD_LAT = 0 / 1 / 2.
- End of test: the cycle after the last operation, busy=0, done=1 for one cycle, pass=1, ram_wren=0. The FSM goes to IDLE via DONE.
- Mismatch:
  - On the compare cycle, capture fail_addr, fail_exp and fail_got.
  - Next cycle: no further writes are issued, busy=0, done=1, pass=0.
  - Only the first mismatch is recorded.
- pass and fail_* hold their values until the next accepted start or reset.
- ram_din = 0 whenever ram_wren = 0.

Optional Feature:
Macro RAM_BIST_CHECKER_EN.
- Defined: after a passing 00/FF run, the full M0–M5 sequence repeats immediately with B0 = 0x55 (checkerboard) and B1 = 0xAA.
  - busy spans both runs (1920 cycles for RD_LAT=1).
  - done pulses once, at the end of the second run or at the first failure.
  - fail_exp reports the pattern that was active when the mismatch occurred.
- Undefined: only the B0 = 0x00 run is performed, and no checkerboard logic is present.

Test Plan:
1. Fault-free behavioural RAM, RD_LAT=1; rst, then one start pulse -> busy high for exactly 960 cycles, then done for 1 cycle, pass=1, fail_* = 0.
2. Bit 3 stuck-at-0 at address 31 -> M2 read fails: pass=0, fail_addr=31, fail_exp=8'hFF, fail_got=8'hF7, and no ram_wren after the failing compare.
3. Bit 0 stuck-at-1 at address 0 -> M1 read fails: pass=0, fail_addr=0, fail_exp=8'h00, fail_got=8'h01.
4. Address bit 5 stuck-at-0 in the RAM model (63 aliases 31) -> M1 fails at the first upper address: fail_addr=32, fail_exp=8'h00, fail_got=8'hFF.
5. Assert rst at cycle 100 of a run -> next edge gives busy=0, ram_wren=0, ram_addr=0, done never pulses. A start pulse during a later run is ignored. A fresh start completes in 960 cycles with pass=1.
6. RD_LAT=0 with an async-read model -> 640 busy cycles, pass=1. With RAM_BIST_CHECKER_EN defined and RD_LAT=1 -> 1920 busy cycles, pass=1.

Source files
------------

// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- built-in self-test initiator for a single-port RAM.
//
// Drives the RAM write-enable, data-in and address pins from registers and
// checks the RAM read data. It runs M0..M5 of March C-, reports pass/fail
// and captures the address, expected data and read data of the first
// mismatch.
//
// Parameters:
//   AW      RAM address width (depth = 2**AW)
//   DW      RAM data width
//   RD_LAT  RAM read latency in clocks (0 = async read, 1, 2)
//
// Ports:
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   start           one-cycle run request, only honoured while idle
//   busy            high while a test runs
//   done            one-cycle pulse at the end of a test (pass or fail)
//   pass            result, valid from done until the next accepted start
//   fail_addr/exp/got  first-mismatch capture
//   ram_wren/din/addr  registered RAM controls
//   ram_dout        RAM read data
//
// Build option: define RAM_BIST_CHECKER_EN to repeat the whole sequence with a
// 0x55/0xAA checkerboard background after a passing all-zeros/all-ones run.

module ram_march_bist #(
    parameter int unsigned AW     = 6,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_exp,
    output logic [DW-1:0] fail_got,
    output logic          ram_wren,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic {PhRead, PhWrite} phase_e;

    localparam logic [1:0]    RdLast  = 2'(RD_LAT);
    localparam logic [AW-1:0] AddrMax = {AW{1'b1}};

`ifdef RAM_BIST_CHECKER_EN
    function automatic logic [DW-1:0] ck_pat();
        logic [DW-1:0] p;
        for (int i = 0; i < int'(DW); i++) begin
            p[i] = (i % 2 == 0);
        end
        return p;
    endfunction

    localparam logic [DW-1:0] CkPat = ck_pat();
`endif

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [2:0]    elem_q, elem_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_exp_q, fail_exp_d;
    logic [DW-1:0] fail_got_q, fail_got_d;
    logic          wren_q, wren_d;
    logic [DW-1:0] din_q, din_d;
    logic [AW-1:0] addr_q, addr_d;
`ifdef RAM_BIST_CHECKER_EN
    logic          run_q, run_d;
`endif

    logic [DW-1:0] bg0, bg1;
    logic [DW-1:0] exp_rd, wr_pat;
    logic          down, last_addr;
    logic          step, fin;

`ifdef RAM_BIST_CHECKER_EN
    assign bg0 = run_q ? CkPat : '0;
`else
    assign bg0 = '0;
`endif
    assign bg1 = ~bg0;

    // Reads in odd elements expect B0, even ones B1; writes are the reverse.
    assign exp_rd = elem_q[0] ? bg0 : bg1;
    assign wr_pat = elem_q[0] ? bg1 : bg0;

    assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign last_addr = down ? (addr_q == '0) : (addr_q == AddrMax);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        elem_d      = elem_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        wren_d      = 1'b0;
        din_d       = '0;
        addr_d      = addr_q;
`ifdef RAM_BIST_CHECKER_EN
        run_d       = run_q;
`endif
        step        = 1'b0;
        fin         = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    elem_d      = 3'd0;
                    phase_d     = PhWrite;
                    cnt_d       = 2'd0;
                    addr_d      = '0;
                    wren_d      = 1'b1;
                    din_d       = '0;
`ifdef RAM_BIST_CHECKER_EN
                    run_d       = 1'b0;
`endif
                end
            end

            StRun: begin
                if (phase_q == PhRead) begin
                    if (cnt_q != RdLast) begin
                        cnt_d = cnt_q + 2'd1;
                    end else if (ram_dout != exp_rd) begin
                        fail_addr_d = addr_q;
                        fail_exp_d  = exp_rd;
                        fail_got_d  = ram_dout;
                        state_d     = StDone;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        pass_d      = 1'b0;
                    end else if (elem_q == 3'd5) begin
                        step = 1'b1;
                    end else begin
                        phase_d = PhWrite;
                        wren_d  = 1'b1;
                        din_d   = wr_pat;
                    end
                end else begin
                    step = 1'b1;
                end

                if (step) begin
                    cnt_d = 2'd0;
                    if (!last_addr) begin
                        addr_d = down ? addr_q - AW'(1) : addr_q + AW'(1);
                        if (elem_q == 3'd0) begin
                            phase_d = PhWrite;
                            wren_d  = 1'b1;
                            din_d   = bg0;
                        end else begin
                            phase_d = PhRead;
                        end
                    end else if (elem_q != 3'd5) begin
                        elem_d  = elem_q + 3'd1;
                        phase_d = PhRead;
                        // M3 and M4 walk downwards from the top address.
                        addr_d  = (elem_q == 3'd2 || elem_q == 3'd3) ? AddrMax : '0;
                    end else begin
`ifdef RAM_BIST_CHECKER_EN
                        if (!run_q) begin
                            run_d   = 1'b1;
                            elem_d  = 3'd0;
                            addr_d  = '0;
                            phase_d = PhWrite;
                            wren_d  = 1'b1;
                            din_d   = CkPat;
                        end else begin
                            fin = 1'b1;
                        end
`else
                        fin = 1'b1;
`endif
                    end
                end

                if (fin) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= PhRead;
            elem_q      <= 3'd0;
            cnt_q       <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
            wren_q      <= 1'b0;
            din_q       <= '0;
            addr_q      <= '0;
`ifdef RAM_BIST_CHECKER_EN
            run_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            elem_q      <= elem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
            wren_q      <= wren_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
`ifdef RAM_BIST_CHECKER_EN
            run_q       <= run_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;
    assign ram_wren  = wren_q;
    assign ram_din   = din_q;
    assign ram_addr  = addr_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (RD_LAT=1 and RD_LAT=0) share one
// behavioural RAM array with injectable faults. A March C- reference model
// predicts the full operation stream and the pass/fail capture.

module tb_ram_march_bist;

    typedef struct packed {
        logic       wren;
        logic [5:0] addr;
        logic [7:0] din;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    logic start1, start0;

    logic       busy1, done1, pass1, wren1;
    logic [5:0] faddr1, addr1;
    logic [7:0] fexp1, fgot1, din1, dout1;
    logic       busy0, done0, pass0, wren0;
    logic [5:0] faddr0, addr0;
    logic [7:0] fexp0, fgot0, din0, dout0;

    logic [7:0] mem [64];

    // Fault environment: 0 none, 1 stuck cell bit, 2 address bit stuck-at-0.
    int         fault_kind = 0;
    logic [5:0] f_addr     = '0;
    int         f_bit      = 0;
    logic       f_val      = 1'b0;
    int         f_abit     = 0;

    int  sel = 1;
    int  checks_cnt = 0;
    int  errors_cnt = 0;

    op_t        exp_q[$];
    logic       m_pass;
    logic [5:0] m_faddr;
    logic [7:0] m_fexp, m_fgot;

    always #5 clk = ~clk;

    ram_march_bist #(.AW(6), .DW(8), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(faddr1), .fail_exp(fexp1), .fail_got(fgot1),
        .ram_wren(wren1), .ram_din(din1), .ram_addr(addr1), .ram_dout(dout1)
    );

    ram_march_bist #(.AW(6), .DW(8), .RD_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_addr(faddr0), .fail_exp(fexp0), .fail_got(fgot0),
        .ram_wren(wren0), .ram_din(din0), .ram_addr(addr0), .ram_dout(dout0)
    );

    function automatic logic [5:0] phys(input logic [5:0] a);
        logic [5:0] p;
        p = a;
        if (fault_kind == 2) p[f_abit] = 1'b0;
        return p;
    endfunction

    function automatic logic [7:0] fdat(input logic [5:0] pa, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (fault_kind == 1 && pa == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (wren1) mem[phys(addr1)] <= fdat(phys(addr1), din1);
        if (wren0) mem[phys(addr0)] <= fdat(phys(addr0), din0);
        dout1 <= mem[phys(addr1)];
    end
    assign dout0 = mem[phys(addr0)];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain March C- walk over a faulty memory array.
    task automatic build_model(input int lat);
        logic [7:0] mm [64];
        logic [7:0] b0, b1, v, e, w;
        logic [5:0] a, pa;
        int         nruns;
`ifdef RAM_BIST_CHECKER_EN
        nruns = 2;
`else
        nruns = 1;
`endif
        exp_q.delete();
        m_pass = 1'b1; m_faddr = '0; m_fexp = '0; m_fgot = '0;
        for (int i = 0; i < 64; i++) mm[i] = 8'h00;
        for (int r = 0; r < nruns && m_pass; r++) begin
            b0 = (r == 1) ? 8'h55 : 8'h00;
            b1 = ~b0;
            for (int el = 0; el < 6 && m_pass; el++) begin
                for (int k = 0; k < 64 && m_pass; k++) begin
                    a  = (el == 3 || el == 4) ? 6'(63 - k) : 6'(k);
                    pa = phys(a);
                    if (el != 0) begin
                        for (int c = 0; c <= lat; c++) exp_q.push_back({1'b0, a, 8'h00});
                        v = mm[pa];
                        e = (el % 2 == 1) ? b0 : b1;
                        if (v !== e) begin
                            m_pass = 1'b0; m_faddr = a; m_fexp = e; m_fgot = v;
                        end
                    end
                    if (m_pass && el != 5) begin
                        w = (el % 2 == 0) ? b0 : b1;
                        exp_q.push_back({1'b1, a, w});
                        mm[pa] = fdat(pa, w);
                    end
                end
            end
        end
    endtask

    task automatic sample(output logic b, output logic d, output logic p, output logic [5:0] fa,
                          output logic [7:0] fe, output logic [7:0] fg, output op_t op);
        if (sel == 1) begin
            b = busy1; d = done1; p = pass1; fa = faddr1; fe = fexp1; fg = fgot1;
            op = {wren1, addr1, din1};
        end else begin
            b = busy0; d = done0; p = pass0; fa = faddr0; fe = fexp0; fg = fgot0;
            op = {wren0, addr0, din0};
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) start1 = v; else start0 = v;
    endtask

    // One full run from start to done, checked cycle by cycle against the model.
    task automatic run_test(input int which, input int extra, input string tag);
        logic b, d, p, trace_ok;
        logic [5:0] fa;
        logic [7:0] fe, fg;
        op_t op;
        int n;
        sel = which;
        build_model(which == 1 ? 1 : 0);
        n = exp_q.size();
        trace_ok = 1'b1;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            sample(b, d, p, fa, fe, fg, op);
            if (trace_ok) begin
                check_eq({tag, "_trace"}, 32'({b, d, op}), 32'({1'b1, 1'b0, exp_q[i]}));
                if ({b, d, op} !== {1'b1, 1'b0, exp_q[i]}) trace_ok = 1'b0;
            end
            set_start(i == extra);
        end
        @(negedge clk);
        set_start(1'b0);
        sample(b, d, p, fa, fe, fg, op);
        check_eq({tag, "_end_busy_done_wren"}, 32'({b, d, op.wren}), 32'({1'b0, 1'b1, 1'b0}));
        check_eq({tag, "_pass"}, 32'(p), 32'(m_pass));
        check_eq({tag, "_fail_addr"}, 32'(fa), 32'(m_faddr));
        check_eq({tag, "_fail_exp"}, 32'(fe), 32'(m_fexp));
        check_eq({tag, "_fail_got"}, 32'(fg), 32'(m_fgot));
        @(negedge clk);
        sample(b, d, p, fa, fe, fg, op);
        check_eq({tag, "_after_done"}, 32'({b, d, op.wren, p}), 32'({1'b0, 1'b0, 1'b0, m_pass}));
    endtask

    task automatic set_fault(input int kind, input logic [5:0] a, input int bt, input logic v,
                             input int ab);
        fault_kind = kind; f_addr = a; f_bit = bt; f_val = v; f_abit = ab;
    endtask

    initial begin
        logic b, d, p;
        logic [5:0] fa;
        logic [7:0] fe, fg;
        op_t op;
        int  done_seen;

        rst = 1'b1; start1 = 1'b0; start0 = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1;
        sample(b, d, p, fa, fe, fg, op);
        check_eq("reset_ctl", 32'({b, d, p}), 32'd0);
        check_eq("reset_fail", 32'({fa, fe, fg}), 32'd0);
        check_eq("reset_ram", 32'(op), 32'd0);
        check_eq("reset_dut0", 32'({busy0, done0, wren0, addr0, din0}), 32'd0);
        rst = 1'b0;

        // Fault-free run at RD_LAT=1.
        set_fault(0, 6'd0, 0, 1'b0, 0);
        run_test(1, -1, "clean_lat1");

        // Plan faults with fixed expectations.
        set_fault(1, 6'd31, 3, 1'b0, 0);
        run_test(1, -1, "bit3_sa0_a31");
        check_eq("bit3_sa0_a31_lit", 32'({faddr1, fexp1, fgot1}), 32'({6'd31, 8'hFF, 8'hF7}));
        set_fault(1, 6'd0, 0, 1'b1, 0);
        run_test(1, -1, "bit0_sa1_a0");
        check_eq("bit0_sa1_a0_lit", 32'({faddr1, fexp1, fgot1}), 32'({6'd0, 8'h00, 8'h01}));
        set_fault(2, 6'd0, 0, 1'b0, 5);
        run_test(1, -1, "abit5_sa0");
        check_eq("abit5_sa0_lit", 32'({faddr1, fexp1, fgot1}), 32'({6'd32, 8'h00, 8'hFF}));

        // Randomised faults with random idle gaps.
        for (int t = 0; t < 4; t++) begin
            set_fault(int'($urandom_range(0, 2)), 6'($urandom_range(0, 63)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_test(1, -1, "rand_fault");
        end

        // Reset in the middle of a run.
        set_fault(0, 6'd0, 0, 1'b0, 0);
        sel = 1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        check_eq("rst_sync_still_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        check_eq("rst_mid_run", 32'({busy1, done1, wren1, addr1}), 32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done1 || busy1) done_seen++;
        end
        check_eq("rst_no_done", 32'(done_seen), 32'd0);

        // Start while busy is ignored; then a fresh clean run.
        run_test(1, int'($urandom_range(50, 400)), "start_while_busy");
        run_test(1, -1, "clean_again");

        // RD_LAT=0 with an async-read RAM.
        run_test(0, -1, "clean_lat0");
        set_fault(1, 6'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 0);
        run_test(0, -1, "fault_lat0");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
